// File: rtl/clock_pkg.sv
// Shared types and constants for the hh:mm:ss timekeeping core.
package clock_pkg;

    typedef enum logic [1:0] {
        RUN   = 2'd0,
        SET_H = 2'd1,
        SET_M = 2'd2,
        SET_S = 2'd3
    } state_e;

    localparam logic [1:0] ST_RUN   = 2'(RUN);
    localparam logic [1:0] ST_SET_H = 2'(SET_H);
    localparam logic [1:0] ST_SET_M = 2'(SET_M);
    localparam logic [1:0] ST_SET_S = 2'(SET_S);

    localparam logic [7:0] BCD_MAX_59 = 8'h59;
    localparam logic [7:0] BCD_MAX_23 = 8'h23;
    localparam logic [7:0] BCD_NOON   = 8'h12;

    // 24h BCD hour (00-23) to 12h BCD hour (01-12)
    function automatic logic [7:0] hour_to_12h(input logic [7:0] h24);
        logic [4:0] bin;
        logic [4:0] b12;
        bin = 5'(h24[7:4]) * 5'd10 + 5'(h24[3:0]);
        if (bin == 5'd0) begin
            b12 = 5'd12;
        end else if (bin > 5'd12) begin
            b12 = bin - 5'd12;
        end else begin
            b12 = bin;
        end
        if (b12 >= 5'd10) begin
            return {4'd1, 4'(b12 - 5'd10)};
        end
        return {4'd0, 4'(b12)};
    endfunction

endpackage

// File: rtl/bcd_field_counter.sv
// Two-digit BCD modulo counter (00..MAX_BCD); wrap flags the MAX_BCD -> 00 step.
module bcd_field_counter #(
    parameter logic [7:0] MAX_BCD = 8'h59
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       en,
    output logic [7:0] value,
    output logic       wrap
);

    logic [7:0] value_nxt;

    assign wrap = en && (value == MAX_BCD);

    always_comb begin
        value_nxt = value;
        if (en) begin
            if (value == MAX_BCD) begin
                value_nxt = 8'h00;
            end else if (value[3:0] == 4'd9) begin
                value_nxt = {value[7:4] + 4'd1, 4'd0};
            end else begin
                value_nxt = {value[7:4], value[3:0] + 4'd1};
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            value <= 8'h00;
        end else begin
            value <= value_nxt;
        end
    end

endmodule

// File: rtl/clock_timekeeper.sv
// Settable hh:mm:ss core: prescaler, set-mode FSM, carry/increment muxing and 12h display mapping.
module clock_timekeeper
    import clock_pkg::*;
#(
    parameter int unsigned TICK_DIV = 100_000_000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       mode_p,
    input  logic       inc_p,
    input  logic       fmt_12h,
    output logic [7:0] sec_bcd,
    output logic [7:0] min_bcd,
    output logic [7:0] hour_bcd,
    output logic       pm,
    output logic [1:0] set_field,
    output logic       chime,
    output logic       day_p
);

    localparam int unsigned PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [PW-1:0] TICK_LAST = PW'(TICK_DIV - 1);

    logic [1:0]    state;
    logic [1:0]    state_nxt;
    logic [PW-1:0] presc;
    logic          in_run;
    logic          inc_ok;
    logic          tick;
    logic          sec_en;
    logic          min_en;
    logic          hour_en;
    logic          sec_wrap;
    logic          min_wrap;
    logic          hour_wrap;
    logic [7:0]    hour_r;

    assign in_run = (state == ST_RUN);
    assign inc_ok = inc_p && !mode_p;
    assign tick   = in_run && (presc == TICK_LAST);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= ST_RUN;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        if (mode_p) begin
            case (state)
                ST_RUN:   state_nxt = ST_SET_H;
                ST_SET_H: state_nxt = ST_SET_M;
                ST_SET_M: state_nxt = ST_SET_S;
                ST_SET_S: state_nxt = ST_RUN;
                default:  state_nxt = ST_RUN;
            endcase
        end
    end

    // Held at 0 outside RUN so the first tick after set mode is a full period away
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            presc <= '0;
        end else if (!in_run || mode_p || tick) begin
            presc <= '0;
        end else begin
            presc <= presc + PW'(1);
        end
    end

    // RUN chains carries; set states bump one field with no carry
    always_comb begin
        sec_en  = 1'b0;
        min_en  = 1'b0;
        hour_en = 1'b0;
        if (in_run) begin
            sec_en  = tick;
            min_en  = sec_wrap;
            hour_en = min_wrap;
        end else begin
            sec_en  = inc_ok && (state == ST_SET_S);
            min_en  = inc_ok && (state == ST_SET_M);
            hour_en = inc_ok && (state == ST_SET_H);
        end
    end

    bcd_field_counter #(.MAX_BCD(BCD_MAX_59)) u_sec (
        .clk   (clk),
        .reset (reset),
        .en    (sec_en),
        .value (sec_bcd),
        .wrap  (sec_wrap)
    );

    bcd_field_counter #(.MAX_BCD(BCD_MAX_59)) u_min (
        .clk   (clk),
        .reset (reset),
        .en    (min_en),
        .value (min_bcd),
        .wrap  (min_wrap)
    );

    bcd_field_counter #(.MAX_BCD(BCD_MAX_23)) u_hour (
        .clk   (clk),
        .reset (reset),
        .en    (hour_en),
        .value (hour_r),
        .wrap  (hour_wrap)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            chime <= 1'b0;
            day_p <= 1'b0;
        end else begin
            chime <= in_run && min_wrap;
            day_p <= in_run && hour_wrap;
        end
    end

    assign set_field = state;
    assign pm        = (hour_r >= BCD_NOON);
    assign hour_bcd  = fmt_12h ? hour_to_12h(hour_r) : hour_r;

endmodule

// File: tb/tb_clock_timekeeper.sv
// Directed bench for clock_timekeeper with TICK_DIV = 4.
module tb_clock_timekeeper;

    logic       clk;
    logic       reset;
    logic       mode_p;
    logic       inc_p;
    logic       fmt_12h;
    logic [7:0] sec_bcd;
    logic [7:0] min_bcd;
    logic [7:0] hour_bcd;
    logic       pm;
    logic [1:0] set_field;
    logic       chime;
    logic       day_p;

    int total = 0;
    int bad   = 0;

    clock_timekeeper #(.TICK_DIV(4)) dut (
        .clk       (clk),
        .reset     (reset),
        .mode_p    (mode_p),
        .inc_p     (inc_p),
        .fmt_12h   (fmt_12h),
        .sec_bcd   (sec_bcd),
        .min_bcd   (min_bcd),
        .hour_bcd  (hour_bcd),
        .pm        (pm),
        .set_field (set_field),
        .chime     (chime),
        .day_p     (day_p)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        bit         mode;
        bit         inc;
        bit         fmt;
        int         reps;
        logic [7:0] e_hour;
        logic       e_pm;
        logic [1:0] e_field;
    } vec_t;

    vec_t vecs[12];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Drive one pulse cycle; returns 1ns after the sampling edge
    task automatic step(input bit m, input bit i);
        @(negedge clk);
        mode_p = m;
        inc_p  = i;
        @(posedge clk);
        #1;
        mode_p = 1'b0;
        inc_p  = 1'b0;
    endtask

    task automatic do_reset();
        reset  = 1'b0;
        mode_p = 1'b0;
        inc_p  = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b1;
    endtask

    task automatic set_time(input int h, input int m, input int s);
        step(1'b1, 1'b0);
        for (int k = 0; k < h; k++) step(1'b0, 1'b1);
        step(1'b1, 1'b0);
        for (int k = 0; k < m; k++) step(1'b0, 1'b1);
        step(1'b1, 1'b0);
        for (int k = 0; k < s; k++) step(1'b0, 1'b1);
        step(1'b1, 1'b0);
    endtask

    initial begin
        int chime_cnt;
        int day_cnt;
        int flag_cnt;

        reset   = 1'b0;
        mode_p  = 1'b0;
        inc_p   = 1'b0;
        fmt_12h = 1'b0;

        // Reset state
        repeat (3) @(posedge clk);
        #2;
        check("rst_sec",   32'(sec_bcd), 32'h00);
        check("rst_min",   32'(min_bcd), 32'h00);
        check("rst_hour",  32'(hour_bcd), 32'h00);
        check("rst_pm",    32'(pm), 32'd0);
        check("rst_field", 32'(set_field), 32'd0);
        check("rst_chime", 32'(chime), 32'd0);
        check("rst_day",   32'(day_p), 32'd0);
        fmt_12h = 1'b1;
        #1;
        check("rst_hour12", 32'(hour_bcd), 32'h12);
        fmt_12h = 1'b0;

        // Free-running count after release
        @(negedge clk);
        reset = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("pre_tick_sec", 32'(sec_bcd), 32'h00);
        @(posedge clk);
        #1;
        check("first_tick_sec", 32'(sec_bcd), 32'h01);
        repeat (236) @(posedge clk);
        #1;
        check("min_roll_min", 32'(min_bcd), 32'h01);
        check("min_roll_sec", 32'(sec_bcd), 32'h00);

        // Table: set-hour increments, 12h mapping, simultaneous pulses, frozen time, RUN inc
        vecs[0]  = '{1'b1, 1'b0, 1'b0, 1,  8'h00, 1'b0, 2'd1};
        vecs[1]  = '{1'b0, 1'b0, 1'b1, 1,  8'h12, 1'b0, 2'd1};
        vecs[2]  = '{1'b0, 1'b1, 1'b1, 12, 8'h12, 1'b1, 2'd1};
        vecs[3]  = '{1'b0, 1'b1, 1'b1, 1,  8'h01, 1'b1, 2'd1};
        vecs[4]  = '{1'b0, 1'b1, 1'b1, 10, 8'h11, 1'b1, 2'd1};
        vecs[5]  = '{1'b0, 1'b0, 1'b0, 1,  8'h23, 1'b1, 2'd1};
        vecs[6]  = '{1'b0, 1'b1, 1'b0, 1,  8'h00, 1'b0, 2'd1};
        vecs[7]  = '{1'b1, 1'b1, 1'b0, 1,  8'h00, 1'b0, 2'd2};
        vecs[8]  = '{1'b0, 1'b0, 1'b0, 40, 8'h00, 1'b0, 2'd2};
        vecs[9]  = '{1'b1, 1'b0, 1'b0, 1,  8'h00, 1'b0, 2'd3};
        vecs[10] = '{1'b1, 1'b0, 1'b0, 1,  8'h00, 1'b0, 2'd0};
        vecs[11] = '{1'b0, 1'b1, 1'b0, 1,  8'h00, 1'b0, 2'd0};

        do_reset();
        flag_cnt = 0;
        for (int v = 0; v < 12; v++) begin
            for (int r = 0; r < vecs[v].reps; r++) begin
                fmt_12h = vecs[v].fmt;
                step(vecs[v].mode, vecs[v].inc);
                if (chime || day_p) flag_cnt++;
            end
            check($sformatf("vec%0d_hour", v),  32'(hour_bcd), 32'(vecs[v].e_hour));
            check($sformatf("vec%0d_pm", v),    32'(pm), 32'(vecs[v].e_pm));
            check($sformatf("vec%0d_field", v), 32'(set_field), 32'(vecs[v].e_field));
            check($sformatf("vec%0d_sec", v),   32'(sec_bcd), 32'h00);
            check($sformatf("vec%0d_min", v),   32'(min_bcd), 32'h00);
        end
        check("table_no_pulse", 32'(flag_cnt), 32'd0);
        fmt_12h = 1'b0;

        // Day rollover from 23:59:58, then hourly chime at 00:59:59 -> 01:00:00
        do_reset();
        set_time(23, 59, 58);
        check("set_hour", 32'(hour_bcd), 32'h23);
        check("set_sec",  32'(sec_bcd), 32'h58);
        chime_cnt = 0;
        day_cnt   = 0;
        for (int c = 1; c <= 12; c++) begin
            @(posedge clk);
            #1;
            if (chime) chime_cnt++;
            if (day_p) day_cnt++;
            if (c == 7) begin
                check("pre_day_time", 32'({hour_bcd, min_bcd, sec_bcd}), 32'h235959);
                check("pre_day_chime", 32'(chime), 32'd0);
            end
            if (c == 8) begin
                check("day_time",  32'({hour_bcd, min_bcd, sec_bcd}), 32'h000000);
                check("day_chime", 32'(chime), 32'd1);
                check("day_day",   32'(day_p), 32'd1);
            end
        end
        check("day_chime_cnt", 32'(chime_cnt), 32'd1);
        check("day_day_cnt",   32'(day_cnt), 32'd1);
        chime_cnt = 0;
        day_cnt   = 0;
        for (int c = 0; c < 14396; c++) begin
            @(posedge clk);
            #1;
            if (chime) chime_cnt++;
            if (day_p) day_cnt++;
        end
        check("hour_time",      32'({hour_bcd, min_bcd, sec_bcd}), 32'h010000);
        check("hour_chime_now", 32'(chime), 32'd1);
        check("hour_chime_cnt", 32'(chime_cnt), 32'd1);
        check("hour_day_cnt",   32'(day_cnt), 32'd0);

        // Asynchronous reset while editing minutes
        do_reset();
        step(1'b1, 1'b0);
        step(1'b1, 1'b0);
        for (int k = 0; k < 37; k++) step(1'b0, 1'b1);
        check("setm_min",   32'(min_bcd), 32'h37);
        check("setm_field", 32'(set_field), 32'd2);
        @(posedge clk);
        #3;
        reset = 1'b0;
        #1;
        check("arst_time",  32'({hour_bcd, min_bcd, sec_bcd}), 32'h000000);
        check("arst_field", 32'(set_field), 32'd0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b1;
        repeat (4) @(posedge clk);
        #1;
        check("arst_resume_sec", 32'(sec_bcd), 32'h01);
        check("arst_resume_min", 32'(min_bcd), 32'h00);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
